// File: rtl/vec_alu_if.sv
// Instruction handshake and writeback/observation bus of vec_alu_pipe.
// The slave modport is the pipeline side; the master modport is the issue/observer side.
interface vec_alu_if #(
    parameter int LANES  = 4,
    parameter int ELEM_W = 8
);
    localparam int VLEN = LANES * ELEM_W;

    logic             instn_valid;
    logic [31:0]      instn;
    logic             instn_ready;
    logic             wb_valid;
    logic [4:0]       wb_addr;
    logic [VLEN-1:0]  wb_data;
    logic [LANES-1:0] lane_ovf;
    logic             ovf_clr;
    logic             overflow_sticky;

    modport slave (
        input  instn_valid, instn, ovf_clr,
        output instn_ready, wb_valid, wb_addr, wb_data, lane_ovf, overflow_sticky
    );

    modport master (
        output instn_valid, instn, ovf_clr,
        input  instn_ready, wb_valid, wb_addr, wb_data, lane_ovf, overflow_sticky
    );
endinterface

// File: rtl/vec_alu_pipe.sv
// Two-stage (ID, EXE) SIMD integer pipeline with a LANES x ELEM_W register file,
// EXE->ID forwarding and a multi-cycle MUL. Define VEC_SAT_EN for saturating ADD/SUB/ADDI.
module vec_alu_pipe #(
    parameter int LANES   = 4,
    parameter int ELEM_W  = 8,
    parameter int MUL_LAT = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    vec_alu_if.slave  bus
);
    localparam int VLEN  = LANES * ELEM_W;
    localparam int CNT_W = $clog2(MUL_LAT + 1);

    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SRL, OP_MUL} op_e;
    typedef enum logic {S_IDLE, S_BUSY} state_e;

    // Returns {overflow, element} for a sign-extended ELEM_W+1 bit sum/difference.
`ifdef VEC_SAT_EN
    function automatic logic [ELEM_W:0] fit_elem(input logic [ELEM_W:0] w);
        if (w[ELEM_W] != w[ELEM_W-1])
            return {1'b1, w[ELEM_W], {(ELEM_W-1){~w[ELEM_W]}}};
        return {1'b0, w[ELEM_W-1:0]};
    endfunction
`else
    function automatic logic [ELEM_W:0] fit_elem(input logic [ELEM_W:0] w);
        return {w[ELEM_W] ^ w[ELEM_W-1], w[ELEM_W-1:0]};
    endfunction
`endif

    logic [VLEN-1:0] rf [32];

    // ID/EXE pipeline register
    logic            vld_p1;
    logic            wr_p1;
    op_e             op_p1;
    logic [4:0]      dest_p1;
    logic [4:0]      shamt_p1;
    logic [VLEN-1:0] a_p1;
    logic [VLEN-1:0] b_p1;

    state_e           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             ready_c;
    logic             exe_wr;
    logic             mul_multi;
    logic             accept;

    logic [VLEN-1:0]  exe_res;
    logic [LANES-1:0] exe_ovf;

    logic             wb_valid_q;
    logic [4:0]       wb_addr_q;
    logic [VLEN-1:0]  wb_data_q;
    logic [LANES-1:0] lane_ovf_q;
    logic             sticky_q;

    // ID stage: decode
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic        dec_wr, dec_use_imm, dec_shift_rt;
    op_e         dec_op;
    logic [4:0]  dec_dest;
    logic signed [ELEM_W-1:0] imm_elem;
    logic [VLEN-1:0] rs_val, rt_val, a_next, b_next;
    logic        fwd_ok;

    assign opcode   = bus.instn[31:26];
    assign rs       = bus.instn[25:21];
    assign rt       = bus.instn[20:16];
    assign rd       = bus.instn[15:11];
    assign shamt    = bus.instn[10:6];
    assign funct    = bus.instn[5:0];
    assign imm_elem = ELEM_W'($signed(bus.instn[15:0]));

    always_comb begin
        dec_wr       = 1'b0;
        dec_op       = OP_ADD;
        dec_dest     = rd;
        dec_use_imm  = 1'b0;
        dec_shift_rt = 1'b0;
        if (opcode == 6'h00) begin
            dec_wr = 1'b1;
            case (funct)
                6'h20:   dec_op = OP_ADD;
                6'h22:   dec_op = OP_SUB;
                6'h24:   dec_op = OP_AND;
                6'h25:   dec_op = OP_OR;
                6'h00:   begin dec_op = OP_SLL; dec_shift_rt = 1'b1; end
                6'h02:   begin dec_op = OP_SRL; dec_shift_rt = 1'b1; end
                6'h18:   dec_op = OP_MUL;
                default: dec_wr = 1'b0;
            endcase
        end else if (opcode == 6'h08) begin
            dec_wr      = 1'b1;
            dec_dest    = rt;
            dec_use_imm = 1'b1;
        end
    end

    // The EXE result bypasses the register file for a dependent instruction in ID.
    assign fwd_ok = vld_p1 & wr_p1 & (dest_p1 != 5'd0);
    assign rs_val = (rs == 5'd0) ? '0 : (fwd_ok && dest_p1 == rs) ? exe_res : rf[rs];
    assign rt_val = (rt == 5'd0) ? '0 : (fwd_ok && dest_p1 == rt) ? exe_res : rf[rt];
    assign a_next = dec_shift_rt ? rt_val : rs_val;
    assign b_next = dec_use_imm ? {LANES{imm_elem}} : rt_val;
    assign accept = bus.instn_valid & ready_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            wr_p1    <= 1'b0;
            op_p1    <= OP_ADD;
            dest_p1  <= '0;
            shamt_p1 <= '0;
            a_p1     <= '0;
            b_p1     <= '0;
        end else if (ready_c) begin
            vld_p1   <= accept;
            wr_p1    <= accept & dec_wr;
            op_p1    <= dec_op;
            dest_p1  <= dec_dest;
            shamt_p1 <= shamt;
            a_p1     <= a_next;
            b_p1     <= b_next;
        end
    end

    // EXE stage: per-lane ALU
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [ELEM_W-1:0] ea, eb;
        logic [ELEM_W-1:0]        res;
        logic [ELEM_W:0]          wide;
        logic                     ovf;

        assign ea = a_p1[i*ELEM_W +: ELEM_W];
        assign eb = b_p1[i*ELEM_W +: ELEM_W];

        always_comb begin
            wide = '0;
            res  = '0;
            ovf  = 1'b0;
            case (op_p1)
                OP_ADD: begin
                    wide       = {ea[ELEM_W-1], ea} + {eb[ELEM_W-1], eb};
                    {ovf, res} = fit_elem(wide);
                end
                OP_SUB: begin
                    wide       = {ea[ELEM_W-1], ea} - {eb[ELEM_W-1], eb};
                    {ovf, res} = fit_elem(wide);
                end
                OP_AND:  res = ea & eb;
                OP_OR:   res = ea | eb;
                OP_SLL:  res = (int'(shamt_p1) >= ELEM_W) ? '0 : ea << shamt_p1;
                OP_SRL:  res = (int'(shamt_p1) >= ELEM_W) ? '0 : ea >> shamt_p1;
                OP_MUL:  res = ea * eb;
                default: res = '0;
            endcase
        end

        assign exe_res[i*ELEM_W +: ELEM_W] = res;
        assign exe_ovf[i]                  = ovf;
    end

    // MUL occupies EXE for MUL_LAT cycles; ID is held until the last one.
    assign mul_multi = vld_p1 && (op_p1 == OP_MUL) && (MUL_LAT > 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        exe_wr  = 1'b0;
        ready_c = 1'b1;
        case (state)
            S_IDLE: begin
                if (mul_multi) begin
                    state_n = S_BUSY;
                    cnt_n   = CNT_W'(MUL_LAT - 1);
                    ready_c = 1'b0;
                end else begin
                    exe_wr = wr_p1;
                end
            end
            S_BUSY: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    exe_wr  = wr_p1;
                    state_n = S_IDLE;
                end else begin
                    ready_c = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Writeback: register file and observation bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) rf[r] <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            lane_ovf_q <= '0;
            sticky_q   <= 1'b0;
        end else begin
            wb_valid_q <= exe_wr;
            if (exe_wr) begin
                wb_addr_q  <= dest_p1;
                wb_data_q  <= exe_res;
                lane_ovf_q <= exe_ovf;
                if (dest_p1 != 5'd0) rf[dest_p1] <= exe_res;
            end
            if (exe_wr && |exe_ovf) sticky_q <= 1'b1;
            else if (bus.ovf_clr)   sticky_q <= 1'b0;
        end
    end

    assign bus.instn_ready     = ready_c;
    assign bus.wb_valid        = wb_valid_q;
    assign bus.wb_addr         = wb_addr_q;
    assign bus.wb_data         = wb_data_q;
    assign bus.lane_ovf        = lane_ovf_q;
    assign bus.overflow_sticky = sticky_q;
endmodule

// File: doc/vec_alu_pipe.md
Name: vec_alu_pipe

Overview:
Parametrised successor of the scalar ID/EXE core: a two-stage (ID, EXE) SIMD integer pipeline with a LANES x ELEM_W vector register file. It uses the same MIPS-style 32-bit instruction word and adds a valid/ready instruction handshake, EXE-to-ID forwarding, a multi-cycle multiply with stall, per-lane overflow and a sticky overflow flag. It sits below the instruction fetch/issue logic and drives the writeback/observation bus.

Parameters:
LANES, 4, number of SIMD lanes (>=1); VLEN = LANES*ELEM_W.
ELEM_W, 8, element width in bits (>=4).
MUL_LAT, 3, EXE occupancy of MUL in cycles (>=1).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
instn_valid  in  1  instn holds a valid instruction.
instn  in  32  instruction word; must be held stable while instn_valid=1 and instn_ready=0.
instn_ready  out  1  ID accepts instn this cycle.
wb_valid  out  1  registered pulse; one result was written.
wb_addr  out  5  destination register of that write.
wb_data  out  VLEN  written vector; lane i is bits [i*ELEM_W +: ELEM_W].
lane_ovf  out  LANES  per-lane signed overflow of the last write.
ovf_clr  in  1  clears overflow_sticky.
overflow_sticky  out  1  OR of every lane_ovf since reset or clear.

Behaviour:
- Decode fields: rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0].
- opcode 0x00 (R-type, dest rd), selected by funct:
  - ADD 0x20, SUB 0x22, AND 0x24, OR 0x25.
  - SLL 0x00 and SRL 0x02 shift rt; shamt>=ELEM_W gives 0.
  - MUL 0x18 keeps the low ELEM_W bits of the signed product.
- opcode 0x08 ADDI (dest rt): imm is sign-extended, truncated to ELEM_W and broadcast to all lanes.
- Any other opcode/funct is a NOP: no write, no wb_valid.
- All lane operations are independent; arithmetic wraps modulo 2^ELEM_W.
- Register file: 32 x VLEN, reset to 0. r0 always reads 0.
  - A write to r0 still pulses wb_valid with wb_addr=0, but r0 stays 0.
- Handshake: accept = instn_valid & instn_ready.
  - On accept, decoded control and operands (rs, rt) are latched into the ID/EXE register.
  - With no accept, a bubble (valid=0) is latched.
- Latency: accepted at edge N, executes in cycle N+1. The RF write and wb_* registers update at edge N+2 for single-cycle ops, or edge N+1+MUL_LAT for MUL.
- Forwarding: when an ID source equals the EXE destination, EXE is valid, writes, and the destination is not r0, ID takes the EXE result combinationally. Back-to-back dependencies therefore never stall.
- EXE FSM:
  - IDLE: single-cycle ops complete here.
  - MUL entering EXE with MUL_LAT>1: go to BUSY with cnt=MUL_LAT-1.
  - BUSY: cnt decrements each cycle; the result is written on the cycle cnt reaches 0, then return to IDLE.
  - instn_ready = 0 while BUSY and cnt!=1; ID/EXE register holds.
  - MUL_LAT=1 behaves as single-cycle.
- Overflow: lane_ovf[i] is the signed overflow of lane i for ADD/SUB/ADDI; it is 0 for other ops.
  - lane_ovf updates only with wb_valid; otherwise it holds.
  - overflow_sticky sets if |lane_ovf_next. When ovf_clr coincides with a new overflow, set wins.
- Reset (asynchronous, also mid-MUL):
  - Clears RF, ID/EXE, FSM to IDLE, cnt=0.
  - wb_valid=0, wb_addr=0, wb_data=0, lane_ovf=0, overflow_sticky=0.
  - instn_ready=1 from the first cycle after release.

Optional Feature:
VEC_SAT_EN
- Defined: ADD/SUB/ADDI saturate per lane to [-2^(ELEM_W-1), 2^(ELEM_W-1)-1]. lane_ovf still reports the lanes that clamped.
- Undefined: wrap-around arithmetic; no saturation logic is instantiated.

Test Plan:
(LANES=4, ELEM_W=8, MUL_LAT=3)
1. Reset with instn_valid=0 -> all outputs 0, instn_ready=1; reset asserted mid-run clears wb_valid next cycle.
2. ADDI r1,r0,5 then ADD r2,r1,r1 on consecutive cycles -> wb writes r1=0x05050505, then r2=0x0A0A0A0A on the next edge, no stall.
3. ADDI r3,r0,127; ADD r4,r3,r3 -> wb_data=0xFEFEFEFE, lane_ovf=4'b1111, overflow_sticky=1. With VEC_SAT_EN -> 0x7F7F7F7F, same flags. ovf_clr then -> sticky=0.
4. ADDI r5,r0,-3; MUL r6,r5,r5 followed by a dependent ADD r7,r6,r0 -> instn_ready low 2 cycles, r6=0x09090909 at 3rd EXE cycle, r7=0x09090909 via forwarding.
5. ADDI r0,r0,7 then OR r8,r0,r0 -> wb_valid with wb_addr=0, then r8=0.
6. Undefined funct 0x3F, then SLL r9,r1,3 and SRL r9,r1,9 -> no wb for the NOP, r9=0x28282828, then r9=0.
